// File: rtl/syscall_pkg.sv
// Shared types and constants for the system-call service unit.
package syscall_pkg;

    // Service-unit control states.
    typedef enum logic [1:0] {
        RUN,
        WAIT_IN,
        HALT
    } state_t;

    // Default service codes ($v0 values) for the MIPS calling convention.
    localparam int unsigned DEF_CODE_PRINT = 1;
    localparam int unsigned DEF_CODE_READ  = 5;
    localparam int unsigned DEF_CODE_EXIT  = 10;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/syscall_unit_if.sv
// Handshake bundle of the service unit: external input word and print queue output.
interface syscall_unit_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Environment side: supplies input words and drains the print queue.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    // Service-unit side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo
    import syscall_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        pop,
    output logic [DATA_W-1:0]           rdata,
    output logic                        full,
    output logic                        empty,
    output logic [count_w(DEPTH)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (count_w(DEPTH))'(DEPTH));
    assign rdata   = mem[rd_ptr];
    // A pop frees the slot a simultaneous push needs when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// System-call service unit: print queue, blocking read, sticky exit.
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CODE_PRINT = DEF_CODE_PRINT,
    parameter int unsigned CODE_READ  = DEF_CODE_READ,
    parameter int unsigned CODE_EXIT  = DEF_CODE_EXIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        syscall,
    input  logic [DATA_W-1:0]           RA,
    input  logic [DATA_W-1:0]           RB,
    syscall_unit_if.slave               io,
    output logic [DATA_W-1:0]           syscall_out,
    output logic                        wb_en,
    output logic [DATA_W-1:0]           wb_data,
    output logic                        stall,
    output logic                        hault,
    output logic [count_w(DEPTH)-1:0]   fifo_count
);

    state_t state;
    state_t state_next;
    logic   push;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push_ok;

    logic   is_print;
    logic   is_read;
    logic   is_exit;

    assign is_print = (RA == DATA_W'(CODE_PRINT));
    assign is_read  = (RA == DATA_W'(CODE_READ));
    assign is_exit  = (RA == DATA_W'(CODE_EXIT));

    // When full, a print can still proceed if the display drains the head this cycle.
    assign push_ok      = !fifo_full || io.out_ready;
    assign io.out_valid = !fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_print_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (RB),
        .pop   (io.out_ready),
        .rdata (io.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Legacy display register: last value accepted by a print.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syscall_out <= '0;
        end else if (push) begin
            syscall_out <= RB;
        end
    end

    // Next-state and control outputs; reset forces every output low at once.
    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        hault       = 1'b0;
        wb_en       = 1'b0;
        wb_data     = '0;
        io.in_ready = 1'b0;
        push        = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (syscall) begin
                        if (is_print) begin
                            if (push_ok) begin
                                push = 1'b1;
                            end else begin
                                stall = 1'b1;
                            end
                        end else if (is_read) begin
                            stall      = 1'b1;
                            state_next = WAIT_IN;
                        end else if (is_exit) begin
                            hault      = 1'b1;
                            stall      = 1'b1;
                            state_next = HALT;
                        end
                    end
                end
                WAIT_IN: begin
                    if (!syscall) begin
                        state_next = RUN;
                    end else begin
                        io.in_ready = 1'b1;
                        if (io.in_valid) begin
                            wb_en      = 1'b1;
                            wb_data    = io.in_data;
                            state_next = RUN;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                HALT: begin
                    hault = 1'b1;
                    stall = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table, directed corner cases, random run.
module tb_syscall_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] sout;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        stall;
    logic        hault;
    logic [3:0]  fcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    syscall_unit_if #(.DATA_W(32)) io ();

    syscall_unit #(
        .DATA_W     (32),
        .DEPTH      (DEPTH),
        .CODE_PRINT (1),
        .CODE_READ  (5),
        .CODE_EXIT  (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .syscall     (sc),
        .RA          (ra),
        .RB          (rb),
        .io          (io),
        .syscall_out (sout),
        .wb_en       (wb_en),
        .wb_data     (wb_data),
        .stall       (stall),
        .hault       (hault),
        .fifo_count  (fcnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue for the print FIFO and a mode number
    // (0 = running, 1 = awaiting input word, 2 = halted).
    logic [31:0] mq[$];
    logic [31:0] m_last;
    int          m_mode;

    task automatic model_check();
        logic e_stall, e_hault, e_inr, e_wb;
        e_hault = (m_mode == 2) || (m_mode == 0 && sc && ra == 32'd10);
        e_inr   = (m_mode == 1) && sc;
        e_wb    = (m_mode == 1) && sc && io.in_valid;
        if (m_mode == 2)      e_stall = 1'b1;
        else if (m_mode == 1) e_stall = sc && !io.in_valid;
        else if (!sc)         e_stall = 1'b0;
        else if (ra == 32'd1) e_stall = (mq.size() == DEPTH) && !io.out_ready;
        else                  e_stall = (ra == 32'd5) || (ra == 32'd10);
        chk("m_stall", 32'(stall), 32'(e_stall));
        chk("m_hault", 32'(hault), 32'(e_hault));
        chk("m_in_ready", 32'(io.in_ready), 32'(e_inr));
        chk("m_wb_en", 32'(wb_en), 32'(e_wb));
        if (e_wb) chk("m_wb_data", wb_data, io.in_data);
        chk("m_out_valid", 32'(io.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("m_out_data", io.out_data, mq[0]);
        chk("m_fifo_count", 32'(fcnt), 32'(mq.size()));
        chk("m_syscall_out", sout, m_last);
    endtask

    task automatic model_update();
        bit pushed;
        pushed = (m_mode == 0) && sc && ra == 32'd1 && (mq.size() < DEPTH || io.out_ready);
        if (mq.size() != 0 && io.out_ready) void'(mq.pop_front());
        if (pushed) begin
            mq.push_back(rb);
            m_last = rb;
        end
        case (m_mode)
            0: if (sc && ra == 32'd5) m_mode = 1;
               else if (sc && ra == 32'd10) m_mode = 2;
            1: if (!sc || io.in_valid) m_mode = 0;
            default: ;
        endcase
    endtask

    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic iv, input logic [31:0] id, input logic ordy);
        sc = s; ra = a; rb = b;
        io.in_valid = iv; io.in_data = id; io.out_ready = ordy;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Asserts reset between clock edges and checks outputs clear without an edge.
    task automatic do_reset(input string nm);
        rst = 1'b1;
        #1;
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        chk({nm, "_hault"}, 32'(hault), 32'd0);
        chk({nm, "_in_ready"}, 32'(io.in_ready), 32'd0);
        chk({nm, "_wb_en"}, 32'(wb_en), 32'd0);
        chk({nm, "_out_valid"}, 32'(io.out_valid), 32'd0);
        chk({nm, "_count"}, 32'(fcnt), 32'd0);
        chk({nm, "_syscall_out"}, sout, 32'd0);
        mq.delete();
        m_last = '0;
        m_mode = 0;
        sc = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        sc;
        logic [31:0] ra, rb;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_stall, e_hault, e_inr, e_wb;
        logic [31:0] e_wbd;
        int          e_cnt;
        logic [31:0] e_sout;
    } vec_t;

    function automatic vec_t mk(bit s, int a, int b, bit iv, int id, bit ordy,
                                bit st, bit ha, bit inr, bit wb, int wbd, int cnt, int so);
        vec_t v;
        v.sc = s; v.ra = a; v.rb = b; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_stall = st; v.e_hault = ha; v.e_inr = inr; v.e_wb = wb;
        v.e_wbd = wbd; v.e_cnt = cnt; v.e_sout = so;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        int halt_cycles;
        sc = 0; ra = 0; rb = 0;
        io.in_valid = 0; io.in_data = 0; io.out_ready = 0;
        #2;
        do_reset("por");

        //            sc ra  rb    iv id      or   st ha inr wb wbd    cnt so
        tbl[0]  = mk(1, 1, 'h2A, 0, 0,      0,   0, 0, 0, 0, 0,      0, 0);
        tbl[1]  = mk(0, 0, 0,    0, 0,      0,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[2]  = mk(1, 5, 0,    0, 0,      0,   1, 0, 0, 0, 0,      1, 'h2A);
        tbl[3]  = mk(1, 5, 0,    0, 0,      0,   1, 0, 1, 0, 0,      1, 'h2A);
        tbl[4]  = mk(1, 5, 0,    0, 0,      0,   1, 0, 1, 0, 0,      1, 'h2A);
        tbl[5]  = mk(1, 5, 0,    0, 0,      0,   1, 0, 1, 0, 0,      1, 'h2A);
        tbl[6]  = mk(1, 5, 0,    1, 'h1234, 0,   0, 0, 1, 1, 'h1234, 1, 'h2A);
        tbl[7]  = mk(0, 0, 0,    0, 0,      0,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[8]  = mk(1, 5, 0,    0, 0,      0,   1, 0, 0, 0, 0,      1, 'h2A);
        tbl[9]  = mk(1, 5, 0,    0, 0,      0,   1, 0, 1, 0, 0,      1, 'h2A);
        tbl[10] = mk(0, 5, 0,    0, 0,      0,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[11] = mk(0, 0, 0,    0, 0,      0,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[12] = mk(1, 7, 0,    0, 0,      0,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[13] = mk(1, 5, 0,    0, 0,      0,   1, 0, 0, 0, 0,      1, 'h2A);
        tbl[14] = mk(0, 5, 0,    0, 0,      0,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[15] = mk(0, 0, 0,    0, 0,      1,   0, 0, 0, 0, 0,      1, 'h2A);
        tbl[16] = mk(0, 0, 0,    0, 0,      1,   0, 0, 0, 0, 0,      0, 'h2A);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].sc, tbl[i].ra, tbl[i].rb, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_hault", i), 32'(hault), 32'(tbl[i].e_hault));
            chk($sformatf("vec%0d_in_ready", i), 32'(io.in_ready), 32'(tbl[i].e_inr));
            chk($sformatf("vec%0d_wb_en", i), 32'(wb_en), 32'(tbl[i].e_wb));
            if (tbl[i].e_wb) chk($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].e_wbd);
            chk($sformatf("vec%0d_count", i), 32'(fcnt), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_syscall_out", i), sout, tbl[i].e_sout);
            tick();
        end

        // Full queue: the ninth print waits until the display pops the head.
        for (int v = 1; v <= 8; v++) begin
            drive(1, 1, 32'(v), 0, 0, 0);
            chk("fill_stall", 32'(stall), 32'd0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 32'd9, 0, 0, 0);
            chk("full_stall", 32'(stall), 32'd1);
            chk("full_count", 32'(fcnt), 32'd8);
            tick();
        end
        drive(1, 1, 32'd9, 0, 0, 1);
        chk("full_pushpop_stall", 32'(stall), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("full_after_count", 32'(fcnt), 32'd8);
        chk("full_after_head", io.out_data, 32'd2);
        chk("full_after_sout", sout, 32'd9);
        for (int v = 2; v <= 9; v++) begin
            drive(0, 0, 0, 0, 0, 1);
            chk("drain_order", io.out_data, 32'(v));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("drain_empty", 32'(fcnt), 32'd0);

        // Exit: halts immediately, later prints are ignored, queue still drains.
        for (int v = 100; v <= 102; v++) begin
            drive(1, 1, 32'(v), 0, 0, 0);
            tick();
        end
        drive(1, 10, 0, 0, 0, 0);
        chk("exit_hault_same_cycle", 32'(hault), 32'd1);
        chk("exit_stall", 32'(stall), 32'd1);
        tick();
        drive(1, 1, 32'd55, 0, 0, 0);
        chk("halt_hault", 32'(hault), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("halt_ignored_print", 32'(fcnt), 32'd3);
        chk("halt_sout", sout, 32'd102);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("halt_drained", 32'(fcnt), 32'd0);
        chk("halt_sticky", 32'(hault), 32'd1);
        do_reset("exit_rst");

        // Reset while awaiting an input word with a non-empty queue.
        drive(1, 1, 32'd7, 0, 0, 0); tick();
        drive(1, 1, 32'd8, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0);
        chk("wait_in_ready", 32'(io.in_ready), 32'd1);
        do_reset("wait_rst");

        // Reset while halted with a non-empty queue.
        drive(1, 1, 32'd3, 0, 0, 0); tick();
        drive(1, 1, 32'd4, 0, 0, 0); tick();
        drive(1, 10, 0, 0, 0, 0); tick();
        drive(1, 1, 32'd9, 0, 0, 0);
        chk("pre_rst_hault", 32'(hault), 32'd1);
        do_reset("halt_rst");

        // Random traffic against the model.
        halt_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            int r;
            if (m_mode == 2) begin
                halt_cycles++;
                if (halt_cycles > 30) begin
                    halt_cycles = 0;
                    do_reset("rnd_rst");
                end
            end
            r = $urandom_range(0, 63);
            if (r == 0)       a = 32'd10;
            else if (r < 30)  a = 32'd1;
            else if (r < 45)  a = 32'd5;
            else              a = 32'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) != 0), a, $urandom, ($urandom_range(0, 3) == 0),
                  $urandom, ($urandom_range(0, 2) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
